// File: rtl/agu_rf_multi_pkg.sv
// Shared AGU register-file definitions: default geometry, sequencer state encoding,
// linear-addressing modifier constant and the address-width helper.
package agu_rf_multi_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 4;

   // An all-ones modifier selects plain linear addressing in the address units.
   localparam logic [DEF_WIDTH-1:0] LINEAR_MOD_VAL = {DEF_WIDTH{1'b1}};

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } agu_rf_state_e;

   function automatic int aw_of(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/agu_rf_rdmux.sv
// One read port: array select, zero for out-of-range addresses, and (with
// AGU_RF_BYPASS_EN) forwarding of same-cycle write or reload data. Zero latency.
module agu_rf_rdmux #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic [AW-1:0]          raddr_i,
   input  logic [DEPTH*WIDTH-1:0] rf_i,
`ifdef AGU_RF_BYPASS_EN
   input  logic                   wr1_vld_i,
   input  logic [AW-1:0]          wr1_addr_i,
   input  logic [WIDTH-1:0]       wr1_dat_i,
   input  logic                   wr2_vld_i,
   input  logic [AW-1:0]          wr2_addr_i,
   input  logic [WIDTH-1:0]       wr2_dat_i,
   input  logic                   swp_vld_i,
   input  logic [AW-1:0]          swp_addr_i,
   input  logic [WIDTH-1:0]       swp_dat_i,
`endif
   output logic [WIDTH-1:0]       rd_o
);

   always_comb begin
      rd_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (raddr_i == AW'(i)) rd_o = rf_i[i*WIDTH +: WIDTH];
      end
`ifdef AGU_RF_BYPASS_EN
      // Later assignments take priority: port 2 over port 1; the sweep never overlaps writes.
      if (wr1_vld_i && (raddr_i == wr1_addr_i)) rd_o = wr1_dat_i;
      if (wr2_vld_i && (raddr_i == wr2_addr_i)) rd_o = wr2_dat_i;
      if (swp_vld_i && (raddr_i == swp_addr_i)) rd_o = swp_dat_i;
`endif
   end

endmodule

// File: rtl/agu_rf_multi.sv
// AGU modifier register file: NRD combinational read ports, two write ports (port 2 wins),
// bulk-reload sequencer taking DEPTH cycles; writes during reload are dropped and flagged.
// Optional same-cycle read bypass under AGU_RF_BYPASS_EN.
module agu_rf_multi
   import agu_rf_multi_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter int               DEPTH     = DEF_DEPTH,
   parameter int               NRD       = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
   localparam int              AW        = aw_of(DEPTH)
) (
   input  logic                 Clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     in1,
   input  logic [WIDTH-1:0]     in2,
   input  logic [AW-1:0]        waddr1,
   input  logic [AW-1:0]        waddr2,
   input  logic                 write1,
   input  logic                 write2,
   input  logic [NRD*AW-1:0]    raddr,
   output logic [NRD*WIDTH-1:0] out,
   input  logic                 init_req,
   input  logic [WIDTH-1:0]     init_val,
   output logic                 busy,
   output logic                 init_done,
   output logic                 wr_err
);

   localparam logic [AW:0]   DEPTH_W  = DEPTH[AW:0];
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   agu_rf_state_e          state_q;
   logic [AW-1:0]          ptr_q;
   logic [WIDTH-1:0]       hold_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   wr_err_q;
   logic [WIDTH-1:0]       rf_q [DEPTH];
   logic [DEPTH*WIDTH-1:0] rf_flat;
   logic                   wr1_ok;
   logic                   wr2_ok;

   assign wr1_ok = write1 && ({1'b0, waddr1} < DEPTH_W);
   assign wr2_ok = write2 && ({1'b0, waddr2} < DEPTH_W);

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) rf_q[i] <= RESET_VAL;
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         hold_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // Port 2 is assigned last so it wins an address collision.
               if (wr1_ok) rf_q[waddr1] <= in1;
               if (wr2_ok) rf_q[waddr2] <= in2;
               if (init_req) begin
                  hold_q  <= init_val;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_SWEEP;
               end
            end
            ST_SWEEP: begin
               rf_q[ptr_q] <= hold_q;
               if (write1 || write2) wr_err_q <= 1'b1;
               if (ptr_q == LAST_PTR) begin
                  ptr_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  ptr_q <= ptr_q + AW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign rf_flat[g*WIDTH +: WIDTH] = rf_q[g];
   end

`ifdef AGU_RF_BYPASS_EN
   logic idle_w;
   logic swp_vld;
   assign idle_w  = (state_q == ST_IDLE);
   assign swp_vld = (state_q == ST_SWEEP);
`endif

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      agu_rf_rdmux #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_rdmux (
         .raddr_i    (raddr[k*AW +: AW]),
         .rf_i       (rf_flat),
`ifdef AGU_RF_BYPASS_EN
         .wr1_vld_i  (wr1_ok && idle_w),
         .wr1_addr_i (waddr1),
         .wr1_dat_i  (in1),
         .wr2_vld_i  (wr2_ok && idle_w),
         .wr2_addr_i (waddr2),
         .wr2_dat_i  (in2),
         .swp_vld_i  (swp_vld),
         .swp_addr_i (ptr_q),
         .swp_dat_i  (hold_q),
`endif
         .rd_o       (out[k*WIDTH +: WIDTH])
      );
   end

   assign busy      = busy_q;
   assign init_done = done_q;
   assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_agu_rf_multi.sv
// Directed bench for agu_rf_multi: default 4x16 instance plus a DEPTH=3 instance for range checks.
module tb_agu_rf_multi;

   logic        Clk;
   logic        reset;
   logic [15:0] in1, in2;
   logic [1:0]  waddr1, waddr2;
   logic        write1, write2;
   logic [5:0]  raddr;
   logic [47:0] out;
   logic        init_req;
   logic [15:0] init_val;
   logic        busy, init_done, wr_err;

   logic [15:0] d3_in1, d3_in2, d3_out, d3_init_val;
   logic [1:0]  d3_waddr1, d3_waddr2, d3_raddr;
   logic        d3_write1, d3_write2, d3_init_req;
   logic        d3_busy, d3_done, d3_wr_err;

   int errors = 0;
   int checks = 0;

   agu_rf_multi u_dut (
      .Clk       (Clk),
      .reset     (reset),
      .in1       (in1),
      .in2       (in2),
      .waddr1    (waddr1),
      .waddr2    (waddr2),
      .write1    (write1),
      .write2    (write2),
      .raddr     (raddr),
      .out       (out),
      .init_req  (init_req),
      .init_val  (init_val),
      .busy      (busy),
      .init_done (init_done),
      .wr_err    (wr_err)
   );

   agu_rf_multi #(.WIDTH(16), .DEPTH(3), .NRD(1)) u_dut3 (
      .Clk       (Clk),
      .reset     (reset),
      .in1       (d3_in1),
      .in2       (d3_in2),
      .waddr1    (d3_waddr1),
      .waddr2    (d3_waddr2),
      .write1    (d3_write1),
      .write2    (d3_write2),
      .raddr     (d3_raddr),
      .out       (d3_out),
      .init_req  (d3_init_req),
      .init_val  (d3_init_val),
      .busy      (d3_busy),
      .init_done (d3_done),
      .wr_err    (d3_wr_err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic        w1;
      logic [1:0]  a1;
      logic [15:0] d1;
      logic        w2;
      logic [1:0]  a2;
      logic [15:0] d2;
      logic [5:0]  ra;
      logic [47:0] exp;
   } vec_t;

   vec_t vt [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      int busy_cnt;
      int done_cnt;
      logic [15:0] exp_byp;

      vt[0] = '{1'b1, 2'd1, 16'h0003, 1'b1, 2'd2, 16'h8000, {2'd2, 2'd1, 2'd0}, {16'h8000, 16'h0003, 16'hFFFF}};
      vt[1] = '{1'b1, 2'd3, 16'h1111, 1'b1, 2'd3, 16'h2222, {2'd3, 2'd3, 2'd0}, {16'h2222, 16'h2222, 16'hFFFF}};
      vt[2] = '{1'b1, 2'd0, 16'h5A5A, 1'b0, 2'd0, 16'hDEAD, {2'd0, 2'd1, 2'd3}, {16'h5A5A, 16'h0003, 16'h2222}};
      vt[3] = '{1'b0, 2'd2, 16'hDEAD, 1'b1, 2'd1, 16'h0BAD, {2'd1, 2'd2, 2'd0}, {16'h0BAD, 16'h8000, 16'h5A5A}};
      vt[4] = '{1'b0, 2'd0, 16'hDEAD, 1'b0, 2'd1, 16'hBEEF, {2'd3, 2'd2, 2'd1}, {16'h2222, 16'h8000, 16'h0BAD}};
      vt[5] = '{1'b1, 2'd0, 16'h1234, 1'b1, 2'd3, 16'h4321, {2'd0, 2'd3, 2'd1}, {16'h1234, 16'h4321, 16'h0BAD}};

      reset = 1'b0; in1 = '0; in2 = '0; waddr1 = '0; waddr2 = '0; write1 = 0; write2 = 0;
      raddr = {2'd2, 2'd1, 2'd0}; init_req = 0; init_val = '0;
      d3_in1 = '0; d3_in2 = '0; d3_waddr1 = '0; d3_waddr2 = '0; d3_write1 = 0; d3_write2 = 0;
      d3_raddr = 2'd2; d3_init_req = 0; d3_init_val = '0;

      // Reset raised mid-cycle must take effect without a clock edge.
      #7 reset = 1'b1;
      #1;
      chk("reset_out", 64'(out), 64'({16'hFFFF, 16'hFFFF, 16'hFFFF}));
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_wr_err", 64'(wr_err), 64'd0);
      chk("reset_done", 64'(init_done), 64'd0);
      chk("d3_reset_rd2", 64'(d3_out), 64'hFFFF);
      #4 reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         write1 = vt[i].w1; waddr1 = vt[i].a1; in1 = vt[i].d1;
         write2 = vt[i].w2; waddr2 = vt[i].a2; in2 = vt[i].d2;
         tick();
         write1 = 0; write2 = 0;
         raddr = vt[i].ra;
         #1;
         chk($sformatf("vec%0d", i), 64'(out), 64'(vt[i].exp));
      end

      // Same-cycle write visibility on read port 0.
`ifdef AGU_RF_BYPASS_EN
      exp_byp = 16'hABCD;
`else
      exp_byp = 16'h1234;
`endif
      raddr = {2'd3, 2'd2, 2'd0};
      write1 = 1; waddr1 = 2'd0; in1 = 16'hABCD;
      #1;
      chk("bypass_same_cycle", 64'(out[15:0]), 64'(exp_byp));
      chk("bypass_other_ports", 64'(out[47:16]), 64'({16'h4321, 16'h8000}));
      tick();
      write1 = 0;
      #1;
      chk("bypass_after_edge", 64'(out[15:0]), 64'hABCD);

      // Bulk reload with an ignored init_req and a dropped write while busy.
      init_req = 1; init_val = 16'h00FF;
      tick();
      init_req = 0;
      busy_cnt = 0; done_cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         if (busy) busy_cnt++;
         if (init_done) begin
            done_cnt++;
            chk("done_busy_low", 64'(busy), 64'd0);
         end
         init_req = (c == 2);
         init_val = (c == 2) ? 16'h1111 : 16'h00FF;
         write1 = (c == 3); waddr1 = 2'd0; in1 = 16'h7777;
         tick();
      end
      init_req = 0; write1 = 0;
      chk("reload_busy_cycles", 64'(busy_cnt), 64'd4);
      chk("reload_done_pulses", 64'(done_cnt), 64'd1);
      raddr = {2'd2, 2'd1, 2'd0};
      #1;
      chk("reload_regs012", 64'(out), 64'({16'h00FF, 16'h00FF, 16'h00FF}));
      raddr = {2'd3, 2'd3, 2'd3};
      #1;
      chk("reload_reg3", 64'(out), 64'({16'h00FF, 16'h00FF, 16'h00FF}));
      chk("wr_err_set", 64'(wr_err), 64'd1);
      tick();
      chk("wr_err_sticky", 64'(wr_err), 64'd1);

      // Reset after two sweep edges aborts the reload.
      init_req = 1; init_val = 16'h00AA;
      tick();
      init_req = 0;
      chk("sweep2_busy", 64'(busy), 64'd1);
      tick();
      tick();
      raddr = {2'd2, 2'd1, 2'd0};
      #2 reset = 1'b1;
      #1;
      chk("abort_out", 64'(out), 64'({16'hFFFF, 16'hFFFF, 16'hFFFF}));
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_wr_err", 64'(wr_err), 64'd0);
      #1 reset = 1'b0;
      busy_cnt = 0; done_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (busy) busy_cnt++;
         if (init_done) done_cnt++;
      end
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      chk("abort_stays_idle", 64'(busy_cnt), 64'd0);
      raddr = {2'd3, 2'd3, 2'd3};
      #1;
      chk("abort_reg3", 64'(out), 64'({16'hFFFF, 16'hFFFF, 16'hFFFF}));

      // Reload accepted normally after the abort.
      init_req = 1; init_val = 16'h0055;
      tick();
      init_req = 0;
      chk("reload2_busy", 64'(busy), 64'd1);
      for (int c = 0; c < 10 && !init_done; c++) tick();
      chk("reload2_done", 64'(init_done), 64'd1);
      raddr = {2'd3, 2'd1, 2'd0};
      #1;
      chk("reload2_regs", 64'(out), 64'({16'h0055, 16'h0055, 16'h0055}));

      // DEPTH=3 instance: address 3 is out of range for both writes and reads.
      d3_write1 = 1; d3_waddr1 = 2'd3; d3_in1 = 16'h1234;
      d3_write2 = 1; d3_waddr2 = 2'd2; d3_in2 = 16'h4444;
      tick();
      d3_write1 = 0; d3_write2 = 0;
      d3_raddr = 2'd2;
      #1;
      chk("d3_write_in_range", 64'(d3_out), 64'h4444);
      d3_raddr = 2'd3;
      #1;
      chk("d3_read_out_of_range", 64'(d3_out), 64'h0000);
      d3_raddr = 2'd0;
      #1;
      chk("d3_reg0_untouched", 64'(d3_out), 64'hFFFF);
      chk("d3_no_wr_err", 64'(d3_wr_err), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/agu_rf_multi.md
Name: agu_rf_multi

Overview:
- Parametrised successor to the AGU modifier-register file: generalised width, depth and read-port count.
- Two write ports with defined collision priority.
- Bulk-reload sequencer that re-initialises every register to a programmable value without asserting core reset.
- Sits in the AGU beside the address/offset files; feeds modifier values to the address arithmetic units.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 4, number of registers (≥2, need not be a power of 2).
- NRD, 3, number of combinational read ports.
- RESET_VAL, {WIDTH{1'b1}}, value loaded into all registers on reset (linear-addressing modifier).
- AW (localparam), max(1, clog2(DEPTH)), address width.

Ports:
- Clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high core reset.
- in1  in  WIDTH  write data, port 1.
- in2  in  WIDTH  write data, port 2.
- waddr1  in  AW  write address, port 1.
- waddr2  in  AW  write address, port 2.
- write1  in  1  write enable, port 1.
- write2  in  1  write enable, port 2.
- raddr  in  NRD*AW  packed read addresses; slice k = port k.
- out  out  NRD*WIDTH  packed read data; slice k = port k.
- init_req  in  1  single-cycle request to start bulk reload.
- init_val  in  WIDTH  reload value, sampled with init_req.
- busy  out  1  high while reload sequencer runs.
- init_done  out  1  one-cycle pulse when reload completes.
- wr_err  out  1  sticky flag: an external write was dropped during reload.

Behaviour:
- Reset (async, immediate):
  - all registers = RESET_VAL
  - FSM = IDLE; pointer = 0; busy = 0; init_done = 0; wr_err = 0
  - out reflects RESET_VAL combinationally.
- Reads:
  - Combinational: out[k] = rf[raddr[k]], zero latency.
  - raddr ≥ DEPTH returns 0.
  - Without the optional feature, a same-cycle write is not visible until after the edge.
- Writes (IDLE only):
  - On the rising edge, write1 stores in1 at waddr1 and write2 stores in2 at waddr2.
  - Both enabled with equal addresses: in2 wins.
  - waddr ≥ DEPTH: that write is ignored, no error.
- FSM states: IDLE, SWEEP.
  - IDLE → SWEEP on init_req. Capture init_val into a holding register; pointer = 0; busy = 1 from the next cycle.
  - SWEEP: each edge writes the held value to rf[pointer] and increments pointer.
  - When pointer == DEPTH-1, that write completes, the FSM returns to IDLE, busy drops, and init_done pulses for exactly one cycle (the first IDLE cycle).
  - Total: busy high for DEPTH cycles.
- Simultaneous events:
  - init_req while busy: ignored.
  - init_req in the same cycle as write1/write2 in IDLE: the writes are performed on that edge; the sweep then overwrites them.
  - External write while busy: dropped, wr_err set (sticky until reset).
  - Reads during SWEEP return current contents (mix of old and reloaded values).
- reset during SWEEP: immediate abort to the reset state; no init_done pulse.

Optional Feature:
- Macro: AGU_RF_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle accepted write data when raddr[k] matches an enabled, in-range write address (in2 has priority over in1).
  - During SWEEP, a read of rf[pointer] forwards the held reload value.
  - Adds one comparator set per read port.
- Undefined: reads are pure array reads, as described under Behaviour.

Decomposition:
- Shared AGU package holds:
  - default WIDTH/DEPTH constants
  - the FSM state encoding (IDLE = 1'b0, SWEEP = 1'b1)
  - the RESET_VAL constant for linear modifier mode
- Optional sub-module agu_rf_rdmux: one read port (array select + out-of-range zero + optional bypass), instantiated NRD times via generate.
- Storage, write logic and FSM stay in the top module.

Test Plan:
- Reset: assert reset mid-cycle with defaults → all out slices read 16'hFFFF immediately; busy = 0, wr_err = 0.
- Dual write, distinct addresses: write1 = 1, waddr1 = 1, in1 = 16'h0003; write2 = 1, waddr2 = 2, in2 = 16'h8000 → after edge, raddr = {2,1,0} gives out = {8000, 0003, FFFF}.
- Collision: waddr1 = waddr2 = 3, in1 = 16'h1111, in2 = 16'h2222 → rf[3] = 2222.
- Reload: init_req with init_val = 16'h00FF → busy high exactly 4 cycles; init_done one pulse; all registers = 00FF. A write1 during busy leaves its target unchanged and sets wr_err = 1.
- Reset during SWEEP: assert reset after 2 sweep cycles → registers FFFF, busy = 0, no init_done pulse. A subsequent init_req is accepted normally.
- Bypass (AGU_RF_BYPASS_EN defined): write1 to address 0 with in1 = 16'hABCD while raddr[0] = 0 → out slice 0 = ABCD in the same cycle. With the macro undefined, the same stimulus reads the old value until after the edge.
